fetch_issue_buffer: RTL and testbench

Decoupling stage directly downstream of the prefetch queue. It accepts up to two in-order instructions per cycle through the queue's ready/consumed handshake and tags each with its PC. It buffers them in a small circular FIFO and issues one instruction per cycle to decode over a valid/ready handshake. A redirect flushes the buffer and restarts PC tagging at the redirect vector.

---
 rtl/fetch_issue_buffer.sv | 100 ++++++++++
 tb/tb_fetch_issue_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_buffer.sv
// fetch_issue_buffer: PC-tagging FIFO between the prefetch queue (2 in/cycle) and decode (1 out/cycle)
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   redirect, redirectVector  flush the buffer and restart PC tagging at redirectVector
//   instruction1/2, instructionReady1/2, instructionConsumed1/2  prefetch queue handshake
//   decodeInstruction, decodePc, decodeValid, decodeReady       decode handshake
//   occupancy                 registered entry count
// Optional: define FETCH_ISSUE_BYPASS_EN to forward instruction1 straight to decode when empty.
module fetch_issue_buffer #(
    parameter int DEPTH = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirectVector,
    input  logic [31:0]              instruction1,
    input  logic                     instructionReady1,
    input  logic [31:0]              instruction2,
    input  logic                     instructionReady2,
    output logic                     instructionConsumed1,
    output logic                     instructionConsumed2,
    output logic [31:0]              decodeInstruction,
    output logic [31:0]              decodePc,
    output logic                     decodeValid,
    input  logic                     decodeReady,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [CW-1:0] count, free;
    logic [AW-1:0] rptr, wptr;
    logic [31:0] pcNext;
    logic [31:0] memInstr [DEPTH];
    logic [31:0] memPc [DEPTH];
    logic fifoValid, deq, wr0En, wr1En;
    logic [31:0] wr0Instr, wr0Pc;
    logic [1:0] enqCount, consumeCount;
`ifdef FETCH_ISSUE_BYPASS_EN
    logic bypassShow;
`endif
    always_comb begin
        free = CW'(DEPTH) - count;
        instructionConsumed1 = !redirect && instructionReady1 && free >= CW'(1);
        instructionConsumed2 = instructionConsumed1 && instructionReady2 && free >= CW'(2);
        fifoValid = count != '0 && !redirect;
        decodeValid = fifoValid;
        decodeInstruction = memInstr[rptr];
        decodePc = memPc[rptr];
        wr0En = instructionConsumed1;
        wr0Instr = instruction1;
        wr0Pc = pcNext;
        wr1En = instructionConsumed2;
`ifdef FETCH_ISSUE_BYPASS_EN
        bypassShow = count == '0 && !redirect && instructionReady1;
        decodeValid = fifoValid || bypassShow;
        decodeInstruction = bypassShow ? instruction1 : decodeInstruction;
        decodePc = bypassShow ? pcNext : decodePc;
        // A taken bypass retires instruction1 directly; only instruction2 lands in the FIFO.
        wr0En = (bypassShow && decodeReady) ? instructionConsumed2 : wr0En;
        wr0Instr = (bypassShow && decodeReady) ? instruction2 : wr0Instr;
        wr0Pc = (bypassShow && decodeReady) ? pcNext + 32'd4 : wr0Pc;
        wr1En = (bypassShow && decodeReady) ? 1'b0 : wr1En;
`endif
        deq = fifoValid && decodeReady;
        enqCount = {1'b0, wr0En} + {1'b0, wr1En};
        consumeCount = {1'b0, instructionConsumed1} + {1'b0, instructionConsumed2};
        occupancy = count;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            rptr <= '0;
            wptr <= '0;
            pcNext <= RESET_VECTOR;
            for (int i = 0; i < DEPTH; i++) begin
                memInstr[i] <= '0;
                memPc[i] <= '0;
            end
        end else if (redirect) begin
            count <= '0;
            rptr <= '0;
            wptr <= '0;
            pcNext <= redirectVector;
        end else begin
            count <= count + CW'(enqCount) - CW'(deq);
            rptr <= rptr + AW'(deq);
            wptr <= wptr + AW'(enqCount);
            pcNext <= pcNext + {28'd0, consumeCount, 2'b00};
            if (wr0En) begin
                memInstr[wptr] <= wr0Instr;
                memPc[wptr] <= wr0Pc;
            end
            if (wr1En) begin
                memInstr[wptr + AW'(1)] <= instruction2;
                memPc[wptr + AW'(1)] <= pcNext + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_fetch_issue_buffer.sv
// tb_fetch_issue_buffer: directed scenarios plus a queue-model random run for fetch_issue_buffer
module tb_fetch_issue_buffer;
    localparam int DEPTH = 4;
    localparam logic [31:0] RV = 32'h00000100;
    logic clock = 1'b0;
    logic reset, redirect, instructionReady1, instructionReady2, decodeReady;
    logic [31:0] redirectVector, instruction1, instruction2;
    logic instructionConsumed1, instructionConsumed2, decodeValid;
    logic [31:0] decodeInstruction, decodePc;
    logic [2:0] occupancy;
    int errors = 0;
    int checks = 0;

    fetch_issue_buffer #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset), .redirect(redirect), .redirectVector(redirectVector),
        .instruction1(instruction1), .instructionReady1(instructionReady1),
        .instruction2(instruction2), .instructionReady2(instructionReady2),
        .instructionConsumed1(instructionConsumed1), .instructionConsumed2(instructionConsumed2),
        .decodeInstruction(decodeInstruction), .decodePc(decodePc),
        .decodeValid(decodeValid), .decodeReady(decodeReady), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        redirect = 1'b0;
        redirectVector = '0;
        instructionReady1 = 1'b0;
        instructionReady2 = 1'b0;
        instruction1 = '0;
        instruction2 = '0;
        decodeReady = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clock);
        checks++; if (decodeValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", decodeValid); end
        checks++; if (decodeInstruction !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", decodeInstruction); end
        checks++; if (decodePc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", decodePc); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if ({instructionConsumed1, instructionConsumed2} !== 2'b00) begin errors++; $display("FAIL reset_consumed got %b want 00", {instructionConsumed1, instructionConsumed2}); end
    endtask

    task automatic test_pair();
        doReset();
        instructionReady1 = 1'b1; instructionReady2 = 1'b1;
        instruction1 = 32'h00000013; instruction2 = 32'h00100093; decodeReady = 1'b1;
        @(negedge clock);
        checks++; if ({instructionConsumed1, instructionConsumed2} !== 2'b11) begin errors++; $display("FAIL pair_consumed got %b want 11", {instructionConsumed1, instructionConsumed2}); end
        checks++; if (decodeValid !== 1'b0) begin errors++; $display("FAIL pair_latency got %b want 0", decodeValid); end
        nextCycle();
        instructionReady1 = 1'b0; instructionReady2 = 1'b0;
        @(negedge clock);
        checks++; if (decodeValid !== 1'b1) begin errors++; $display("FAIL pair_valid1 got %b want 1", decodeValid); end
        checks++; if (decodePc !== RV) begin errors++; $display("FAIL pair_pc1 got %h want %h", decodePc, RV); end
        checks++; if (decodeInstruction !== 32'h00000013) begin errors++; $display("FAIL pair_instr1 got %h want 00000013", decodeInstruction); end
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL pair_occ got %0d want 2", occupancy); end
        nextCycle();
        @(negedge clock);
        checks++; if (decodePc !== RV + 32'd4) begin errors++; $display("FAIL pair_pc2 got %h want %h", decodePc, RV + 32'd4); end
        checks++; if (decodeInstruction !== 32'h00100093) begin errors++; $display("FAIL pair_instr2 got %h want 00100093", decodeInstruction); end
        nextCycle();
        @(negedge clock);
        checks++; if (decodeValid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL pair_drain got v=%b occ=%0d want v=0 occ=0", decodeValid, occupancy); end
    endtask

    task automatic test_fill();
        doReset();
        instructionReady1 = 1'b1; instructionReady2 = 1'b1;
        instruction1 = $urandom; instruction2 = $urandom;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c < 2) begin
                checks++; if ({instructionConsumed1, instructionConsumed2} !== 2'b11) begin errors++; $display("FAIL fill_take%0d got %b want 11", c, {instructionConsumed1, instructionConsumed2}); end
            end else begin
                checks++; if ({instructionConsumed1, instructionConsumed2} !== 2'b00) begin errors++; $display("FAIL fill_full%0d got %b want 00", c, {instructionConsumed1, instructionConsumed2}); end
                checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ%0d got %0d want 4", c, occupancy); end
            end
            nextCycle();
        end
    endtask

    task automatic fillThree();
        doReset();
        instructionReady1 = 1'b1; instructionReady2 = 1'b1;
        instruction1 = 32'h11111111; instruction2 = 32'h22222222;
        nextCycle();
        instructionReady2 = 1'b0; instruction1 = 32'h33333333;
        nextCycle();
    endtask

    task automatic test_partial();
        fillThree();
        instructionReady1 = 1'b1; instructionReady2 = 1'b1; decodeReady = 1'b1;
        instruction1 = 32'h44444444; instruction2 = 32'h55555555;
        @(negedge clock);
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL partial_occ0 got %0d want 3", occupancy); end
        checks++; if ({instructionConsumed1, instructionConsumed2} !== 2'b10) begin errors++; $display("FAIL partial_consumed got %b want 10", {instructionConsumed1, instructionConsumed2}); end
        checks++; if (decodePc !== RV) begin errors++; $display("FAIL partial_pc got %h want %h", decodePc, RV); end
        nextCycle();
        instructionReady1 = 1'b0; instructionReady2 = 1'b0;
        @(negedge clock);
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL partial_occ1 got %0d want 3", occupancy); end
        checks++; if (decodePc !== RV + 32'd4) begin errors++; $display("FAIL partial_pc1 got %h want %h", decodePc, RV + 32'd4); end
    endtask

    task automatic test_redirect();
        fillThree();
        redirect = 1'b1; redirectVector = 32'd40;
        instructionReady1 = 1'b1; instructionReady2 = 1'b1; decodeReady = 1'b1;
        @(negedge clock);
        checks++; if (decodeValid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", decodeValid); end
        checks++; if ({instructionConsumed1, instructionConsumed2} !== 2'b00) begin errors++; $display("FAIL redir_consumed got %b want 00", {instructionConsumed1, instructionConsumed2}); end
        nextCycle();
        redirect = 1'b0; instructionReady2 = 1'b0; decodeReady = 1'b0; instruction1 = 32'hAAAA0001;
        @(negedge clock);
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL redir_occ got %0d want 0", occupancy); end
        nextCycle();
        instruction1 = 32'hAAAA0002;
        @(negedge clock);
        checks++; if (decodePc !== 32'd40) begin errors++; $display("FAIL redir_pc0 got %h want 40", decodePc); end
        nextCycle();
        instructionReady1 = 1'b0; decodeReady = 1'b1;
        @(negedge clock);
        checks++; if (decodePc !== 32'd40 || decodeInstruction !== 32'hAAAA0001) begin errors++; $display("FAIL redir_hold got %h/%h want 00000028/aaaa0001", decodePc, decodeInstruction); end
        nextCycle();
        @(negedge clock);
        checks++; if (decodePc !== 32'd44 || decodeInstruction !== 32'hAAAA0002) begin errors++; $display("FAIL redir_pc1 got %h/%h want 0000002c/aaaa0002", decodePc, decodeInstruction); end
        redirect = 1'b1; redirectVector = 32'd100;
        nextCycle();
        redirectVector = 32'd200;
        nextCycle();
        redirect = 1'b0; instructionReady1 = 1'b1; decodeReady = 1'b0;
        nextCycle();
        instructionReady1 = 1'b0;
        @(negedge clock);
        checks++; if (decodePc !== 32'd200 || decodeValid !== 1'b1) begin errors++; $display("FAIL redir_b2b got pc=%h v=%b want pc=000000c8 v=1", decodePc, decodeValid); end
    endtask

    task automatic test_wrap();
        int idx = 0;
        int issued = 0;
        doReset();
        for (int c = 0; c < 200 && issued < 12; c++) begin
            instructionReady1 = idx < 12;
            instructionReady2 = idx + 1 < 12;
            instruction1 = 32'hA0000000 + idx;
            instruction2 = 32'hA0000001 + idx;
            decodeReady = (c % 2) == 0;
            @(negedge clock);
            if (decodeValid && decodeReady) begin
                checks++; if (decodePc !== RV + 32'(4 * issued) || decodeInstruction !== 32'hA0000000 + issued) begin errors++; $display("FAIL wrap_issue%0d got %h/%h want %h/%h", issued, decodePc, decodeInstruction, RV + 32'(4 * issued), 32'hA0000000 + issued); end
                issued++;
            end
            idx += int'(instructionConsumed1) + int'(instructionConsumed2);
            nextCycle();
        end
        instructionReady1 = 1'b0; instructionReady2 = 1'b0;
        checks++; if (issued != 12) begin errors++; $display("FAIL wrap_count got %0d want 12", issued); end
        @(negedge clock);
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", occupancy); end
    endtask

    task automatic test_async_reset();
        doReset();
        instructionReady1 = 1'b1; instructionReady2 = 1'b1; instruction1 = 32'h0BADF00D; instruction2 = 32'h0BADF00E;
        nextCycle();
        instructionReady1 = 1'b0; instructionReady2 = 1'b0; redirect = 1'b1; redirectVector = 32'h0000DEAD;
        @(negedge clock);
        redirect = 1'b0;
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL areset_pre got %0d want 2", occupancy); end
        nextCycle();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (decodeValid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL areset_now got v=%b occ=%0d want v=0 occ=0", decodeValid, occupancy); end
        reset = 1'b0;
        instructionReady1 = 1'b1; instruction1 = 32'h00C0FFEE;
        nextCycle();
        instructionReady1 = 1'b0;
        @(negedge clock);
        checks++; if (decodePc !== RV || decodeInstruction !== 32'h00C0FFEE) begin errors++; $display("FAIL areset_pc got %h/%h want %h/00c0ffee", decodePc, decodeInstruction, RV); end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [31:0] mpc;
        int free;
        logic e1, e2, ev;
        doReset();
        mpc = RV;
        for (int c = 0; c < 400; c++) begin
            redirect = $urandom_range(15) == 0;
            redirectVector = {$urandom_range(1023), 2'b00};
            instructionReady1 = $urandom_range(3) != 0;
            instructionReady2 = $urandom_range(1) != 0;
            instruction1 = $urandom;
            instruction2 = $urandom;
            decodeReady = $urandom_range(2) != 0;
            @(negedge clock);
            free = DEPTH - q.size();
            e1 = !redirect && instructionReady1 && free >= 1;
            e2 = e1 && instructionReady2 && free >= 2;
            ev = q.size() != 0 && !redirect;
            checks++; if ({instructionConsumed1, instructionConsumed2} !== {e1, e2}) begin errors++; $display("FAIL rnd_consumed c%0d got %b want %b", c, {instructionConsumed1, instructionConsumed2}, {e1, e2}); end
            checks++; if (decodeValid !== ev) begin errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, decodeValid, ev); end
            checks++; if (occupancy !== 3'(q.size())) begin errors++; $display("FAIL rnd_occ c%0d got %0d want %0d", c, occupancy, q.size()); end
            if (ev) begin
                checks++; if ({decodeInstruction, decodePc} !== q[0]) begin errors++; $display("FAIL rnd_head c%0d got %h want %h", c, {decodeInstruction, decodePc}, q[0]); end
            end
            nextCycle();
            if (redirect) begin
                q.delete();
                mpc = redirectVector;
            end else begin
                if (ev && decodeReady) void'(q.pop_front());
                if (e1) begin q.push_back({instruction1, mpc}); mpc += 4; end
                if (e2) begin q.push_back({instruction2, mpc}); mpc += 4; end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_fill();
        test_partial();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
